// File: rtl/opprep_pipe_pkg.sv
// Shared types and constants for the operand-preparation stage (package p_hardisc).
package p_hardisc;

  localparam int unsigned OPPREP_FWD_MAX = 4;
  // Width at which forwarded values travel; XLEN must not exceed it.
  localparam int unsigned OPPREP_XLEN    = 32;

  typedef logic [4:0] rf_add;

  typedef struct packed {
    rf_add                  rd;
    logic                   we;
    logic                   rdy;
    logic [OPPREP_XLEN-1:0] val;
  } fwd_port_t;

  function automatic logic rf_live(input logic used, input rf_add addr);
    return used & (addr != '0);
  endfunction

endpackage

// File: rtl/opprep_scoreboard.sv
// Pending-writeback scoreboard for long-latency producers.
// Optional OPPREP_SB_DUP_EN keeps a shadow vector and flags divergence on err_o.
module opprep_scoreboard
  import p_hardisc::*;
(
  input  logic  s_clk_i,
  input  logic  s_rst_i,
  input  logic  set_i,
  input  rf_add set_rd_i,
  input  logic  clr_i,
  input  rf_add clr_rd_i,
  input  rf_add rs1_i,
  input  rf_add rs2_i,
  input  rf_add rd_i,
  output logic  rs1_pend_o,
  output logic  rs2_pend_o,
  output logic  rd_pend_o,
  output logic  err_o
);

  logic [31:0] set_vec, clr_vec, pend_d, pend_q, pend_look;

  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    if (set_i && set_rd_i != '0) set_vec[set_rd_i] = 1'b1;
    if (clr_i) clr_vec[clr_rd_i] = 1'b1;
    // Set is applied after clear so a same-cycle collision stays pending.
    pend_d = (pend_q & ~clr_vec) | set_vec;
  end

  always_ff @(posedge s_clk_i) begin
    if (s_rst_i) pend_q <= '0;
    else         pend_q <= pend_d;
  end

`ifdef OPPREP_SB_DUP_EN
  logic [31:0] pend2_q;
  logic        err_q;

  always_ff @(posedge s_clk_i) begin
    if (s_rst_i) begin
      pend2_q <= '0;
      err_q   <= 1'b0;
    end else begin
      pend2_q <= (pend2_q & ~clr_vec) | set_vec;
      err_q   <= |(pend_q ^ pend2_q);
    end
  end

  assign pend_look = (pend_q | pend2_q) & ~clr_vec;
  assign err_o     = err_q;
`else
  assign pend_look = pend_q & ~clr_vec;
  assign err_o     = 1'b0;
`endif

  assign rs1_pend_o = pend_look[rs1_i];
  assign rs2_pend_o = pend_look[rs2_i];
  assign rd_pend_o  = pend_look[rd_i];

endmodule

// File: rtl/opprep_pipe.sv
// Operand preparation: forwarding, hazard detection and a one-deep output register.
// Build option OPPREP_SB_DUP_EN duplicates the scoreboard (see opprep_scoreboard).
module opprep_pipe
  import p_hardisc::*;
#(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned FWD_STAGES = 3
) (
  input  logic                       s_clk_i,
  input  logic                       s_rst_i,
  input  logic                       s_in_valid_i,
  output logic                       s_in_ready_o,
  input  logic [4:0]                 s_rs1_i,
  input  logic [4:0]                 s_rs2_i,
  input  logic [1:0]                 s_rs_use_i,
  input  logic [4:0]                 s_rd_i,
  input  logic                       s_rd_we_i,
  input  logic                       s_long_i,
  input  logic [XLEN-1:0]            s_rf_p1_i,
  input  logic [XLEN-1:0]            s_rf_p2_i,
  input  logic [XLEN-1:0]            s_imm_i,
  input  logic                       s_imm_sel_i,
  input  logic [5*FWD_STAGES-1:0]    s_fwd_rd_i,
  input  logic [FWD_STAGES-1:0]      s_fwd_we_i,
  input  logic [FWD_STAGES-1:0]      s_fwd_rdy_i,
  input  logic [XLEN*FWD_STAGES-1:0] s_fwd_val_i,
  input  logic                       s_lwb_valid_i,
  input  logic [4:0]                 s_lwb_rd_i,
  input  logic [XLEN-1:0]            s_lwb_val_i,
  input  logic                       s_flush_i,
  output logic                       s_out_valid_o,
  input  logic                       s_out_ready_i,
  output logic [XLEN-1:0]            s_op1_o,
  output logic [XLEN-1:0]            s_op2_o,
  output logic [4:0]                 s_rd_o,
  output logic                       s_rd_we_o,
  output logic [15:0]                s_stall_cnt_o,
  output logic                       s_sb_err_o
);

  localparam int unsigned NumFwd = (FWD_STAGES > OPPREP_FWD_MAX) ? OPPREP_FWD_MAX : FWD_STAGES;

  fwd_port_t       fwd [NumFwd];
  rf_add           rs [2];
  logic [XLEN-1:0] rf_val [2];
  logic [XLEN-1:0] opv [2];
  logic [1:0]      fwd_stall, sb_pend, live, src_haz;
  logic            rd_pend, waw, hazard, accept;

  logic            out_valid_d, out_valid_q, rd_we_d, rd_we_q;
  logic [XLEN-1:0] op1_d, op1_q, op2_d, op2_q;
  rf_add           rd_d, rd_q;
  logic [15:0]     stall_d, stall_q;

  for (genvar i = 0; i < NumFwd; i++) begin : g_fwd
    assign fwd[i].rd  = s_fwd_rd_i[5*i +: 5];
    assign fwd[i].we  = s_fwd_we_i[i];
    assign fwd[i].rdy = s_fwd_rdy_i[i];
    assign fwd[i].val = OPPREP_XLEN'(s_fwd_val_i[XLEN*i +: XLEN]);
  end

  assign rs[0]     = s_rs1_i;
  assign rs[1]     = s_rs2_i;
  assign rf_val[0] = s_rf_p1_i;
  assign rf_val[1] = s_rf_p2_i;

  // The youngest matching producer wins; if it is not ready the source must wait.
  always_comb begin : p_opsel
    logic found;
    found = 1'b0;
    for (int k = 0; k < 2; k++) begin
      found        = 1'b0;
      opv[k]       = rf_val[k];
      fwd_stall[k] = 1'b0;
      for (int i = 0; i < NumFwd; i++) begin
        if (!found && fwd[i].we && fwd[i].rd == rs[k]) begin
          found        = 1'b1;
          opv[k]       = XLEN'(fwd[i].val);
          fwd_stall[k] = ~fwd[i].rdy;
        end
      end
      if (!found && s_lwb_valid_i && s_lwb_rd_i == rs[k]) opv[k] = s_lwb_val_i;
      if (rs[k] == '0) opv[k] = '0;
    end
  end

  opprep_scoreboard u_sb (
    .s_clk_i    (s_clk_i),
    .s_rst_i    (s_rst_i),
    .set_i      (accept & s_rd_we_i & s_long_i),
    .set_rd_i   (s_rd_i),
    .clr_i      (s_lwb_valid_i),
    .clr_rd_i   (s_lwb_rd_i),
    .rs1_i      (s_rs1_i),
    .rs2_i      (s_rs2_i),
    .rd_i       (s_rd_i),
    .rs1_pend_o (sb_pend[0]),
    .rs2_pend_o (sb_pend[1]),
    .rd_pend_o  (rd_pend),
    .err_o      (s_sb_err_o)
  );

  assign live[0] = rf_live(s_rs_use_i[0], s_rs1_i);
  assign live[1] = rf_live(s_rs_use_i[1], s_rs2_i);

  for (genvar k = 0; k < 2; k++) begin : g_haz
    assign src_haz[k] = live[k] & ((out_valid_q & rd_we_q & (rd_q == rs[k]))
                                   | sb_pend[k] | fwd_stall[k]);
  end

  assign waw          = s_rd_we_i & (s_rd_i != '0) & rd_pend;
  assign hazard       = (|src_haz) | waw;
  assign s_in_ready_o = (~out_valid_q | s_out_ready_i) & ~hazard & ~s_flush_i;
  assign accept       = s_in_valid_i & s_in_ready_o;

  always_comb begin
    out_valid_d = out_valid_q;
    op1_d       = op1_q;
    op2_d       = op2_q;
    rd_d        = rd_q;
    rd_we_d     = rd_we_q;
    if (s_flush_i) begin
      out_valid_d = 1'b0;
    end else if (accept) begin
      out_valid_d = 1'b1;
      op1_d       = opv[0];
      op2_d       = s_imm_sel_i ? s_imm_i : opv[1];
      rd_d        = s_rd_i;
      rd_we_d     = s_rd_we_i;
    end else if (s_out_ready_i) begin
      out_valid_d = 1'b0;
    end
    stall_d = stall_q;
    if (s_in_valid_i && hazard && !s_flush_i && stall_q != 16'hFFFF) stall_d = stall_q + 16'd1;
  end

  always_ff @(posedge s_clk_i) begin
    if (s_rst_i) begin
      out_valid_q <= 1'b0;
      op1_q       <= '0;
      op2_q       <= '0;
      rd_q        <= '0;
      rd_we_q     <= 1'b0;
      stall_q     <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      op1_q       <= op1_d;
      op2_q       <= op2_d;
      rd_q        <= rd_d;
      rd_we_q     <= rd_we_d;
      stall_q     <= stall_d;
    end
  end

  assign s_out_valid_o = out_valid_q;
  assign s_op1_o       = op1_q;
  assign s_op2_o       = op2_q;
  assign s_rd_o        = rd_q;
  assign s_rd_we_o     = rd_we_q;
  assign s_stall_cnt_o = stall_q;

endmodule

// File: tb/tb_opprep_pipe.sv
// Self-checking bench for opprep_pipe: directed scenarios plus randomized traffic
// against a behavioural model of pending registers and the output slot.
module tb_opprep_pipe;

  localparam int XL = 32;
  localparam int FW = 3;

  logic          s_clk, s_rst;
  logic          s_in_valid, s_in_ready;
  logic [4:0]    s_rs1, s_rs2, s_rd;
  logic [1:0]    s_rs_use;
  logic          s_rd_we, s_long;
  logic [XL-1:0] s_rf_p1, s_rf_p2, s_imm;
  logic          s_imm_sel;
  logic [4:0]    f_rd [FW];
  logic          f_we [FW];
  logic          f_rdy [FW];
  logic [XL-1:0] f_val [FW];
  logic [5*FW-1:0]  s_fwd_rd;
  logic [FW-1:0]    s_fwd_we, s_fwd_rdy;
  logic [XL*FW-1:0] s_fwd_val;
  logic          s_lwb_valid;
  logic [4:0]    s_lwb_rd;
  logic [XL-1:0] s_lwb_val;
  logic          s_flush, s_out_valid, s_out_ready;
  logic [XL-1:0] s_op1, s_op2;
  logic [4:0]    s_rd_o;
  logic          s_rd_we_o;
  logic [15:0]   s_stall_cnt;
  logic          s_sb_err;

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit            m_pend [32];
  bit            m_valid, m_rd_we;
  logic [XL-1:0] m_op1, m_op2;
  logic [4:0]    m_rd;
  logic [15:0]   m_stall;

  always_comb begin
    for (int i = 0; i < FW; i++) begin
      s_fwd_rd[5*i +: 5]    = f_rd[i];
      s_fwd_we[i]           = f_we[i];
      s_fwd_rdy[i]          = f_rdy[i];
      s_fwd_val[XL*i +: XL] = f_val[i];
    end
  end

  opprep_pipe #(.XLEN(XL), .FWD_STAGES(FW)) dut (
    .s_clk_i       (s_clk),
    .s_rst_i       (s_rst),
    .s_in_valid_i  (s_in_valid),
    .s_in_ready_o  (s_in_ready),
    .s_rs1_i       (s_rs1),
    .s_rs2_i       (s_rs2),
    .s_rs_use_i    (s_rs_use),
    .s_rd_i        (s_rd),
    .s_rd_we_i     (s_rd_we),
    .s_long_i      (s_long),
    .s_rf_p1_i     (s_rf_p1),
    .s_rf_p2_i     (s_rf_p2),
    .s_imm_i       (s_imm),
    .s_imm_sel_i   (s_imm_sel),
    .s_fwd_rd_i    (s_fwd_rd),
    .s_fwd_we_i    (s_fwd_we),
    .s_fwd_rdy_i   (s_fwd_rdy),
    .s_fwd_val_i   (s_fwd_val),
    .s_lwb_valid_i (s_lwb_valid),
    .s_lwb_rd_i    (s_lwb_rd),
    .s_lwb_val_i   (s_lwb_val),
    .s_flush_i     (s_flush),
    .s_out_valid_o (s_out_valid),
    .s_out_ready_i (s_out_ready),
    .s_op1_o       (s_op1),
    .s_op2_o       (s_op2),
    .s_rd_o        (s_rd_o),
    .s_rd_we_o     (s_rd_we_o),
    .s_stall_cnt_o (s_stall_cnt),
    .s_sb_err_o    (s_sb_err)
  );

  initial s_clk = 1'b0;
  always #5 s_clk = ~s_clk;

  function automatic bit pend_now(input logic [4:0] r);
    return m_pend[r] && !(s_lwb_valid && s_lwb_rd == r);
  endfunction

  function automatic logic [XL-1:0] m_operand(input logic [4:0] r, input logic [XL-1:0] rf);
    if (r == 5'd0) return '0;
    for (int i = 0; i < FW; i++) if (f_we[i] && f_rd[i] == r) return f_val[i];
    if (s_lwb_valid && s_lwb_rd == r) return s_lwb_val;
    return rf;
  endfunction

  function automatic bit m_src_haz(input bit used, input logic [4:0] r);
    if (!used || r == 5'd0) return 1'b0;
    if (m_valid && m_rd_we && m_rd == r) return 1'b1;
    if (pend_now(r)) return 1'b1;
    for (int i = 0; i < FW; i++) if (f_we[i] && f_rd[i] == r) return !f_rdy[i];
    return 1'b0;
  endfunction

  function automatic bit m_hazard();
    return m_src_haz(s_rs_use[0], s_rs1) || m_src_haz(s_rs_use[1], s_rs2) ||
           (s_rd_we && s_rd != 5'd0 && pend_now(s_rd));
  endfunction

  task automatic idle();
    s_in_valid = 0; s_rs1 = 0; s_rs2 = 0; s_rs_use = 0; s_rd = 0; s_rd_we = 0;
    s_long = 0; s_rf_p1 = 0; s_rf_p2 = 0; s_imm = 0; s_imm_sel = 0;
    for (int i = 0; i < FW; i++) begin
      f_rd[i] = 0; f_we[i] = 0; f_rdy[i] = 1; f_val[i] = 0;
    end
    s_lwb_valid = 0; s_lwb_rd = 0; s_lwb_val = 0; s_flush = 0; s_out_ready = 1;
  endtask

  // One clock with the currently driven inputs, checked against the model.
  task automatic step(input string tag);
    bit hz, rdy, acc;
    logic [XL-1:0] e1, e2;
    #1;
    hz  = m_hazard();
    rdy = (!m_valid || s_out_ready) && !hz && !s_flush;
    e1  = m_operand(s_rs1, s_rf_p1);
    e2  = s_imm_sel ? s_imm : m_operand(s_rs2, s_rf_p2);
    acc = s_in_valid && rdy;
    checks++;
    if (s_in_ready !== rdy) begin
      errors++;
      $display("FAIL %s ready: got %b exp %b", tag, s_in_ready, rdy);
    end
    @(posedge s_clk);
    if (s_in_valid && hz && !s_flush && m_stall != 16'hFFFF) m_stall++;
    if (s_lwb_valid) m_pend[s_lwb_rd] = 1'b0;
    if (acc && s_rd_we && s_long && s_rd != 5'd0) m_pend[s_rd] = 1'b1;
    if (s_flush) m_valid = 1'b0;
    else if (acc) begin
      m_valid = 1'b1; m_op1 = e1; m_op2 = e2; m_rd = s_rd; m_rd_we = s_rd_we;
    end else if (s_out_ready) m_valid = 1'b0;
    #1;
    checks++;
    if (s_out_valid !== m_valid || s_op1 !== m_op1 || s_op2 !== m_op2 ||
        s_rd_o !== m_rd || s_rd_we_o !== m_rd_we) begin
      errors++;
      $display("FAIL %s out: got v=%b op1=%h op2=%h rd=%0d we=%b exp v=%b op1=%h op2=%h rd=%0d we=%b",
               tag, s_out_valid, s_op1, s_op2, s_rd_o, s_rd_we_o,
               m_valid, m_op1, m_op2, m_rd, m_rd_we);
    end
    checks++;
    if (s_stall_cnt !== m_stall || s_sb_err !== 1'b0) begin
      errors++;
      $display("FAIL %s stall/err: got %0d/%b exp %0d/0", tag, s_stall_cnt, s_sb_err, m_stall);
    end
  endtask

  task automatic test_reset();
    idle();
    s_rst = 1'b1;
    @(posedge s_clk);
    #1;
    s_rst = 1'b0;
    for (int i = 0; i < 32; i++) m_pend[i] = 1'b0;
    m_valid = 0; m_rd_we = 0; m_op1 = 0; m_op2 = 0; m_rd = 0; m_stall = 0;
    checks++;
    if (s_out_valid !== 0 || s_op1 !== 0 || s_op2 !== 0 || s_rd_o !== 0 ||
        s_rd_we_o !== 0 || s_stall_cnt !== 0 || s_sb_err !== 0 || s_in_ready !== 1) begin
      errors++;
      $display("FAIL reset: got v=%b op1=%h op2=%h rd=%0d we=%b cnt=%0d err=%b rdy=%b exp all 0, rdy=1",
               s_out_valid, s_op1, s_op2, s_rd_o, s_rd_we_o, s_stall_cnt, s_sb_err, s_in_ready);
    end
  endtask

  task automatic test_fwd_priority();
    idle();
    s_in_valid = 1; s_rs1 = 5; s_rs2 = 6; s_rs_use = 2'b11; s_rd = 1; s_rd_we = 1;
    s_rf_p1 = 32'h44; s_rf_p2 = 32'h33;
    f_rd[0] = 5; f_we[0] = 1; f_val[0] = 32'h11;
    f_rd[2] = 5; f_we[2] = 1; f_val[2] = 32'h22;
    step("fwd_prio");
    checks++;
    if (s_op1 !== 32'h11 || s_op2 !== 32'h33) begin
      errors++;
      $display("FAIL fwd_prio ops: got %h/%h exp 00000011/00000033", s_op1, s_op2);
    end
    idle(); step("fwd_prio_drain");
  endtask

  task automatic test_long();
    idle();
    s_in_valid = 1; s_rd = 7; s_rd_we = 1; s_long = 1;
    step("long_issue");
    idle();
    s_in_valid = 1; s_rs1 = 7; s_rs_use = 2'b01; s_rf_p1 = 32'h5;
    for (int c = 0; c < 4; c++) step("long_wait");
    checks++;
    if (s_in_ready !== 1'b0 || s_stall_cnt !== 16'd4) begin
      errors++;
      $display("FAIL long_stall: got rdy=%b cnt=%0d exp rdy=0 cnt=4", s_in_ready, s_stall_cnt);
    end
    s_lwb_valid = 1; s_lwb_rd = 7; s_lwb_val = 32'hAB;
    step("long_wb");
    checks++;
    if (s_op1 !== 32'hAB || s_out_valid !== 1'b1) begin
      errors++;
      $display("FAIL long_wb op1: got %h v=%b exp 000000ab v=1", s_op1, s_out_valid);
    end
    idle(); step("long_drain");
  endtask

  task automatic test_same_cycle_set_clr();
    idle();
    s_in_valid = 1; s_rd = 9; s_rd_we = 1; s_long = 1;
    s_lwb_valid = 1; s_lwb_rd = 9; s_lwb_val = 32'h99;
    step("setclr_issue");
    idle(); step("setclr_gap");
    s_in_valid = 1; s_rs2 = 9; s_rs_use = 2'b10;
    step("setclr_read");
    checks++;
    if (s_in_ready !== 1'b0) begin
      errors++;
      $display("FAIL setclr_pending: got rdy=%b exp 0", s_in_ready);
    end
    s_lwb_valid = 1; s_lwb_rd = 9; step("setclr_wb");
    idle(); step("setclr_drain");
  endtask

  task automatic test_hold_flush();
    idle();
    s_in_valid = 1; s_rs1 = 3; s_rs_use = 2'b01; s_rf_p1 = 32'hCAFE; s_imm = 32'h77;
    s_imm_sel = 1; s_rd = 12; s_rd_we = 1; s_long = 1; s_out_ready = 0;
    step("hold_issue");
    idle(); s_out_ready = 0; s_in_valid = 1; s_rs1 = 4; s_rs_use = 2'b01;
    step("hold_1");
    step("hold_2");
    checks++;
    if (s_out_valid !== 1 || s_op1 !== 32'hCAFE || s_op2 !== 32'h77 || s_rd_o !== 5'd12) begin
      errors++;
      $display("FAIL hold_stable: got v=%b op1=%h op2=%h rd=%0d exp 1/0000cafe/00000077/12",
               s_out_valid, s_op1, s_op2, s_rd_o);
    end
    idle(); s_out_ready = 0; s_flush = 1;
    step("flush");
    checks++;
    if (s_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_valid: got %b exp 0", s_out_valid);
    end
    idle(); s_in_valid = 1; s_rs1 = 12; s_rs_use = 2'b01;
    step("flush_pend");
    checks++;
    if (s_in_ready !== 1'b0) begin
      errors++;
      $display("FAIL flush_pend_kept: got rdy=%b exp 0", s_in_ready);
    end
    s_lwb_valid = 1; s_lwb_rd = 12; s_lwb_val = 32'h1212; step("flush_wb");
    idle(); step("flush_drain");
  endtask

  task automatic test_x0();
    idle();
    s_in_valid = 1; s_rs_use = 2'b11; s_rd = 0; s_rd_we = 1; s_long = 1;
    s_rf_p1 = 32'hDEAD; s_rf_p2 = 32'hBEEF;
    f_rd[0] = 0; f_we[0] = 1; f_rdy[0] = 0; f_val[0] = 32'h5555;
    s_lwb_valid = 1; s_lwb_rd = 0; s_lwb_val = 32'h6666;
    step("x0_issue");
    step("x0_again");
    checks++;
    if (s_op1 !== 0 || s_op2 !== 0 || s_in_ready !== 1'b1 || s_stall_cnt !== m_stall) begin
      errors++;
      $display("FAIL x0: got op1=%h op2=%h rdy=%b cnt=%0d exp 0/0/1/%0d",
               s_op1, s_op2, s_in_ready, s_stall_cnt, m_stall);
    end
    idle(); step("x0_drain");
  endtask

  task automatic test_random(input int n);
    for (int c = 0; c < n; c++) begin
      s_in_valid  = ($urandom_range(0, 3) != 0);
      s_rs1       = 5'($urandom_range(0, 7));
      s_rs2       = 5'($urandom_range(0, 7));
      s_rs_use    = 2'($urandom_range(0, 3));
      s_rd        = 5'($urandom_range(0, 7));
      s_rd_we     = 1'($urandom_range(0, 1));
      s_long      = ($urandom_range(0, 3) == 0);
      s_rf_p1     = $urandom;
      s_rf_p2     = $urandom;
      s_imm       = $urandom;
      s_imm_sel   = 1'($urandom_range(0, 1));
      for (int i = 0; i < FW; i++) begin
        f_rd[i]  = 5'($urandom_range(0, 7));
        f_we[i]  = 1'($urandom_range(0, 1));
        f_rdy[i] = ($urandom_range(0, 3) != 0);
        f_val[i] = $urandom;
      end
      s_lwb_valid = ($urandom_range(0, 3) == 0);
      s_lwb_rd    = 5'($urandom_range(0, 7));
      s_lwb_val   = $urandom;
      s_flush     = ($urandom_range(0, 15) == 0);
      s_out_ready = ($urandom_range(0, 3) != 0);
      step("random");
    end
  endtask

  task automatic test_reset_midop();
    idle();
    s_in_valid = 1; s_rd = 15; s_rd_we = 1; s_long = 1; s_out_ready = 0;
    step("midop_issue");
    test_reset();
    s_lwb_valid = 1; s_lwb_rd = 15; step("midop_late_wb");
    idle(); s_in_valid = 1; s_rs1 = 15; s_rs_use = 2'b01; s_rf_p1 = 32'h1515;
    step("midop_read");
    checks++;
    if (s_op1 !== 32'h1515 || s_out_valid !== 1'b1) begin
      errors++;
      $display("FAIL midop_read: got op1=%h v=%b exp 00001515 v=1", s_op1, s_out_valid);
    end
    idle(); step("midop_drain");
  endtask

  task automatic test_saturate();
    idle();
    s_in_valid = 1; s_rd = 20; s_rd_we = 1; s_long = 1;
    step("sat_issue");
    idle(); s_in_valid = 1; s_rs1 = 20; s_rs_use = 2'b01;
    for (int c = 0; c < 65600; c++) step("sat");
    checks++;
    if (s_stall_cnt !== 16'hFFFF) begin
      errors++;
      $display("FAIL saturate: got %h exp ffff", s_stall_cnt);
    end
    s_lwb_valid = 1; s_lwb_rd = 20; step("sat_wb");
    idle(); step("sat_drain");
  endtask

`ifdef OPPREP_SB_DUP_EN
  task automatic test_dup_err();
    test_reset();
    force dut.u_sb.pend2_q = 32'h0000_0008;
    @(posedge s_clk);
    #1;
    checks++;
    if (s_sb_err !== 1'b1) begin
      errors++;
      $display("FAIL dup_err: got %b exp 1", s_sb_err);
    end
    s_in_valid = 1; s_rs1 = 3; s_rs_use = 2'b01;
    #1;
    checks++;
    if (s_in_ready !== 1'b0) begin
      errors++;
      $display("FAIL dup_stall: got rdy=%b exp 0", s_in_ready);
    end
    release dut.u_sb.pend2_q;
    test_reset();
  endtask
`endif

  initial begin
    test_reset();
    test_fwd_priority();
    test_long();
    test_same_cycle_set_clr();
    test_hold_flush();
    test_x0();
    test_random(600);
    test_reset_midop();
    test_saturate();
`ifdef OPPREP_SB_DUP_EN
    test_dup_err();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/opprep_pipe.md
OPPREP_PIPE -- requirements
Module: opprep_pipe

Interface
REQ-001 Parameter XLEN, default 32, operand width.
REQ-002 Parameter FWD_STAGES, default 3, range 1..4, number of downstream forwarding ports; port 0 is the youngest.
REQ-003 s_clk_i  in  1  single clock; all state updates on rising edge.
REQ-004 s_rst_i  in  1  reset, synchronous, active-high.
REQ-005 s_in_valid_i in 1 / s_in_ready_o out 1  upstream handshake.
REQ-006 s_rs1_i, s_rs2_i  in  5 each  source register addresses.
REQ-007 s_rs_use_i  in  2  bit k: source k+1 is read.
REQ-008 s_rd_i in 5 / s_rd_we_i in 1 / s_long_i in 1  destination, write enable, long-latency producer flag.
REQ-009 s_rf_p1_i, s_rf_p2_i  in  XLEN each  register-file read values.
REQ-010 s_imm_i in XLEN / s_imm_sel_i in 1  immediate and operand-2 immediate select.
REQ-011 s_fwd_rd_i in 5*FWD_STAGES / s_fwd_we_i in FWD_STAGES / s_fwd_rdy_i in FWD_STAGES / s_fwd_val_i in XLEN*FWD_STAGES  downstream producers.
REQ-012 s_lwb_valid_i in 1 / s_lwb_rd_i in 5 / s_lwb_val_i in XLEN  long-latency writeback.
REQ-013 s_flush_i  in  1  pipeline kill.
REQ-014 s_out_valid_o out 1 / s_out_ready_i in 1  downstream handshake.
REQ-015 s_op1_o, s_op2_o out XLEN / s_rd_o out 5 / s_rd_we_o out 1  registered prepared instruction.
REQ-016 s_stall_cnt_o  out  16  saturating hazard-stall cycle count.
REQ-017 s_sb_err_o  out  1  scoreboard integrity error.

Function
REQ-018 Source k is live when use bit set and rsk != 0; x0 reads yield 0 and never hazard.
REQ-019 Hazard: live source matching valid output-register rd with rd_we; or matching pending scoreboard entry not cleared by same-cycle lwb; or first matching fwd port having rdy=0.
REQ-020 WAW hazard: s_rd_we_i with rd != 0 whose scoreboard entry is pending and not cleared this cycle.
REQ-021 s_in_ready_o = (~s_out_valid_o | s_out_ready_i) & ~hazard & ~s_flush_i, combinational.
REQ-022 Operand priority: fwd port 0 .. FWD_STAGES-1 (lowest index first, we=1, match), then lwb port (valid, match), then RF value.
REQ-023 s_op2_o takes s_imm_i when s_imm_sel_i, regardless of rs2.
REQ-024 Accept (valid & ready) loads output register next edge; latency 1 cycle; s_out_valid_o set.
REQ-025 Output register holds unchanged while s_out_valid_o & ~s_out_ready_i.
REQ-026 Consume without accept clears s_out_valid_o next edge.
REQ-027 Scoreboard: 32 pending bits; set on accept with rd_we & s_long_i & rd != 0; cleared on s_lwb_valid_i for s_lwb_rd_i; simultaneous set and clear of same bit: set wins.
REQ-028 s_flush_i clears s_out_valid_o next edge; scoreboard untouched (issued long ops still write back).
REQ-029 s_stall_cnt_o increments when s_in_valid_i & hazard & ~s_flush_i; saturates at 16'hFFFF.

Reset
REQ-030 On s_rst_i: s_out_valid_o, s_op1_o, s_op2_o, s_rd_o, s_rd_we_o, s_stall_cnt_o, s_sb_err_o, all pending bits = 0.
REQ-031 Reset mid-operation discards held instruction and outstanding pending bits; late lwb clears are harmless.

Configuration
REQ-032 Macro OPPREP_SB_DUP_EN: enabled, a second identically-updated pending vector is kept; hazard uses bitwise OR of copies; any mismatch sets s_sb_err_o one cycle later (held one cycle per mismatch cycle).
REQ-033 Macro absent: single pending vector, s_sb_err_o tied 0, port retained.

Structure
REQ-034 rf_add reuse, constant OPPREP_FWD_MAX=4, and a fwd-port struct (rd, we, rdy, val) reside in p_hardisc.
REQ-035 Scoreboard (set/clear/lookup, duplication) is sub-module opprep_scoreboard.

Verification
REQ-036 Accept rs1=5, rs2=6; fwd0 rd=5 we rdy val=0x11, fwd2 rd=5 val=0x22, RF p2=0x33 -> next cycle op1=0x11, op2=0x33.
REQ-037 Long op rd=7 accepted; next op reads x7 -> ready=0 and counter increments each cycle; lwb rd=7 val=0xAB -> same cycle ready=1, op1=0xAB.
REQ-038 Same-cycle accept long rd=9 and lwb rd=9 -> bit 9 remains pending.
REQ-039 out_ready=0 two cycles with valid output -> outputs stable; flush -> out_valid=0 next cycle, pending bits unchanged.
REQ-040 Reads/writes of x0 with long flag -> op=0, no stall, no pending bit.
REQ-041 OPPREP_SB_DUP_EN: force copy-2 bit 3 -> s_sb_err_o=1 next cycle, rs=3 stalls; 65600 forced stall cycles -> counter 16'hFFFF.
